// File: rtl/banco_registros_p_if.sv
// rtl/banco_registros_p_if.sv - register bank port bundle: write port, two read ports, clear handshake
interface banco_registros_p_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic             enable_w;
    logic [AW-1:0]    write_data;
    logic [WIDTH-1:0] data;
    logic [AW-1:0]    read_data1;
    logic [AW-1:0]    read_data2;
    logic [WIDTH-1:0] out_d1;
    logic [WIDTH-1:0] out_d2;
    logic             clr_req;
    logic             clr_busy;
    logic             clr_done;
    logic             wr_drop;

    modport master (
        output enable_w, write_data, data, read_data1, read_data2, clr_req,
        input  out_d1, out_d2, clr_busy, clr_done, wr_drop
    );

    modport slave (
        input  enable_w, write_data, data, read_data1, read_data2, clr_req,
        output out_d1, out_d2, clr_busy, clr_done, wr_drop
    );
endinterface

// File: rtl/banco_registros_p.sv
// rtl/banco_registros_p.sv - parametrised register bank with bulk-clear sweep; optional REGFILE_BYPASS_EN forwarding
module banco_registros_p #(
    parameter int              WIDTH      = 32,
    parameter int              DEPTH      = 32,
    parameter int              INIT_COUNT = 7,
    parameter logic [WIDTH-1:0] INIT_VAL  = 32'h00000001,
    parameter bit              ZERO_REG   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    banco_registros_p_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

    // One-hot-style encoding so busy/done are each a single flop bit
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SWEEP = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] bank [DEPTH];
    logic             wr_accept;
    logic             fwd1;
    logic             fwd2;

    function automatic logic [WIDTH-1:0] clear_value(input int n);
        return (n < INIT_COUNT) ? INIT_VAL : '0;
    endfunction

    // Writes land only while idle; register 0 is read-only when hard-wired to zero
    assign wr_accept = bus.enable_w && (state == IDLE) &&
                       !(ZERO_REG && (bus.write_data == '0));

`ifdef REGFILE_BYPASS_EN
    assign fwd1 = wr_accept && (bus.read_data1 == bus.write_data);
    assign fwd2 = wr_accept && (bus.read_data2 == bus.write_data);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: idle until a clear request, sweep every register once, one done cycle
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.clr_req) state_nx = SWEEP;
            SWEEP:   if (idx == IDX_LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded straight from the state flops
    always_comb begin
        bus.clr_busy = (state == SWEEP);
        bus.clr_done = (state == DONE);
    end

    // Sweep index: restarted on entry to the sweep, advances one register per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               idx <= '0;
        else if (state == IDLE && bus.clr_req) idx <= '0;
        else if (state == SWEEP)               idx <= idx + 1'b1;
    end

    // Storage: reset pattern, sweep clears, or a normal write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= clear_value(i);
        end else if (state == SWEEP) begin
            bank[idx] <= clear_value(int'(idx));
        end else if (wr_accept) begin
            bank[bus.write_data] <= bus.data;
        end
    end

    // Flag every requested write that did not land, one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.wr_drop <= 1'b0;
        else     bus.wr_drop <= bus.enable_w && !wr_accept;
    end

    // Read port 1
    always_comb begin
        bus.out_d1 = bank[bus.read_data1];
        if (fwd1) bus.out_d1 = bus.data;
        if (ZERO_REG && (bus.read_data1 == '0)) bus.out_d1 = '0;
    end

    // Read port 2
    always_comb begin
        bus.out_d2 = bank[bus.read_data2];
        if (fwd2) bus.out_d2 = bus.data;
        if (ZERO_REG && (bus.read_data2 == '0)) bus.out_d2 = '0;
    end
endmodule
